// File: rtl/out_port_hex_display.sv
// out_port_hex_display
// Converts three 32-bit CPU output ports to two-digit decimal on six active-low
// seven-segment displays. A single shift-and-add-3 engine visits the channels
// round-robin: LOAD (1) + SHIFT (7) + STORE (1) = 9 cycles per channel.
// Values above 99 are shown as two dashes and flagged in ovf.
module out_port_hex_display #(
  parameter logic LEAD_BLANK = 1'b0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [2:0]  ovf,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    STORE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  ch;
  logic [2:0]  cnt;
  logic [6:0]  bin;
  logic [7:0]  bcd;
  logic        over;
  logic [31:0] port_sel;
  logic [6:0]  tens_seg;
  logic [6:0]  ones_seg;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [7:0] bcd_adjust(input logic [7:0] b);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = b[7:4];
    lo = b[3:0];
    if (hi >= 4'd5) hi = hi + 4'd3;
    if (lo >= 4'd5) lo = lo + 4'd3;
    return {hi, lo};
  endfunction

  // Active-low gfedcba pattern for a decimal digit; anything else is blank.
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Select the port belonging to the channel currently being converted.
  always_comb begin
    port_sel = 32'd0;
    case (ch)
      2'd0:    port_sel = out_port0;
      2'd1:    port_sel = out_port1;
      2'd2:    port_sel = out_port2;
      default: port_sel = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= LOAD;
    else         state <= state_nxt;
  end

  // Next-state logic: one LOAD, seven SHIFTs, one STORE, repeat.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (cnt == 3'd6) state_nxt = STORE;
      STORE:   state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Conversion datapath: snapshot on LOAD, double-dabble during SHIFT.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bin  <= 7'd0;
      bcd  <= 8'd0;
      cnt  <= 3'd0;
      over <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          over <= (port_sel > 32'd99);
          bin  <= port_sel[6:0];
          bcd  <= 8'd0;
          cnt  <= 3'd0;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adjust(bcd), bin} << 1;
          cnt        <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Display patterns for the finished conversion, including dash and blanking.
  always_comb begin
    tens_seg = seg(bcd[7:4]);
    ones_seg = seg(bcd[3:0]);
    if (over) begin
      tens_seg = SEG_DASH;
      ones_seg = SEG_DASH;
    end else if (LEAD_BLANK && (bcd[7:4] == 4'd0)) begin
      tens_seg = SEG_BLANK;
    end
  end

  // Output registers and channel rotation; written only on STORE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      HEX0       <= SEG_BLANK;
      HEX1       <= SEG_BLANK;
      HEX2       <= SEG_BLANK;
      HEX3       <= SEG_BLANK;
      HEX4       <= SEG_BLANK;
      HEX5       <= SEG_BLANK;
      ovf        <= 3'b000;
      frame_done <= 1'b0;
      ch         <= 2'd0;
    end else begin
      frame_done <= 1'b0;
      if (state == STORE) begin
        case (ch)
          2'd0: begin
            HEX1   <= tens_seg;
            HEX0   <= ones_seg;
            ovf[0] <= over;
          end
          2'd1: begin
            HEX3   <= tens_seg;
            HEX2   <= ones_seg;
            ovf[1] <= over;
          end
          2'd2: begin
            HEX5   <= tens_seg;
            HEX4   <= ones_seg;
            ovf[2] <= over;
          end
          default: ;
        endcase
        frame_done <= (ch == 2'd2);
        ch         <= (ch == 2'd2) ? 2'd0 : ch + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_out_port_hex_display.sv
// Testbench for out_port_hex_display: two instances (LEAD_BLANK 0 and 1) share
// inputs and are compared against a schedule-based decimal reference model.
module tb_out_port_hex_display;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] p_in [3];
  logic [6:0]  a_hex [6];
  logic [6:0]  b_hex [6];
  logic [2:0]  a_ovf, b_ovf;
  logic        a_fd, b_fd;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  out_port_hex_display #(.LEAD_BLANK(1'b0)) dut_a (
    .clock(clock), .resetn(resetn),
    .out_port0(p_in[0]), .out_port1(p_in[1]), .out_port2(p_in[2]),
    .HEX0(a_hex[0]), .HEX1(a_hex[1]), .HEX2(a_hex[2]),
    .HEX3(a_hex[3]), .HEX4(a_hex[4]), .HEX5(a_hex[5]),
    .ovf(a_ovf), .frame_done(a_fd)
  );

  out_port_hex_display #(.LEAD_BLANK(1'b1)) dut_b (
    .clock(clock), .resetn(resetn),
    .out_port0(p_in[0]), .out_port1(p_in[1]), .out_port2(p_in[2]),
    .HEX0(b_hex[0]), .HEX1(b_hex[1]), .HEX2(b_hex[2]),
    .HEX3(b_hex[3]), .HEX4(b_hex[4]), .HEX5(b_hex[5]),
    .ovf(b_ovf), .frame_done(b_fd)
  );

  // Reference model: edge n after reset release sits at frame position
  // (n-1) mod 27; channel = pos/9, phase 0 samples the port, phase 8 shows it.
  int          ecnt  = 0;
  int          m_pos = -1;
  logic [31:0] snap [3] = '{default: 32'd0};
  logic [6:0]  e_hex [2][6] = '{default: '{default: 7'h7F}};
  logic [2:0]  e_ovf = 3'b000;
  logic        e_fd  = 1'b0;

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always @(posedge clock or negedge resetn) begin : model
    int c, ph, vt, vo;
    if (!resetn) begin
      ecnt  = 0;
      m_pos = -1;
      e_ovf = 3'b000;
      e_fd  = 1'b0;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 6; i++) e_hex[k][i] = 7'h7F;
      for (int i = 0; i < 3; i++) snap[i] = 32'd0;
    end else begin
      ecnt  = ecnt + 1;
      m_pos = (ecnt - 1) % 27;
      c     = m_pos / 9;
      ph    = m_pos % 9;
      e_fd  = 1'b0;
      if (ph == 0) snap[c] = p_in[c];
      if (ph == 8) begin
        if (snap[c] > 32'd99) begin
          for (int k = 0; k < 2; k++) begin
            e_hex[k][2*c+1] = 7'h3F;
            e_hex[k][2*c]   = 7'h3F;
          end
          e_ovf[c] = 1'b1;
        end else begin
          vt = int'(snap[c]) / 10;
          vo = int'(snap[c]) % 10;
          e_hex[0][2*c+1] = dig(vt);
          e_hex[1][2*c+1] = (vt == 0) ? 7'h7F : dig(vt);
          e_hex[0][2*c]   = dig(vo);
          e_hex[1][2*c]   = dig(vo);
          e_ovf[c] = 1'b0;
        end
        e_fd = (c == 2);
      end
    end
  end

  logic [45:0] obs_a, obs_b, exp_a, exp_b;
  assign obs_a = {a_hex[5], a_hex[4], a_hex[3], a_hex[2], a_hex[1], a_hex[0], a_ovf, a_fd};
  assign obs_b = {b_hex[5], b_hex[4], b_hex[3], b_hex[2], b_hex[1], b_hex[0], b_ovf, b_fd};
  assign exp_a = {e_hex[0][5], e_hex[0][4], e_hex[0][3], e_hex[0][2], e_hex[0][1], e_hex[0][0], e_ovf, e_fd};
  assign exp_b = {e_hex[1][5], e_hex[1][4], e_hex[1][3], e_hex[1][2], e_hex[1][1], e_hex[1][0], e_ovf, e_fd};

  localparam logic [45:0] ALL_BLANK = {{6{7'h7F}}, 3'b000, 1'b0};

  task automatic test_reset();
    p_in[0] = 32'd5; p_in[1] = 32'd5; p_in[2] = 32'd5;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (obs_a !== ALL_BLANK) begin fails++; $display("FAIL reset_a: got %h expected %h", obs_a, ALL_BLANK); end
    checks++;
    if (obs_b !== ALL_BLANK) begin fails++; $display("FAIL reset_b: got %h expected %h", obs_b, ALL_BLANK); end
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if (obs_a !== exp_a) begin fails++; $display("FAIL reset_model cyc %0d: got %h expected %h", i, obs_a, exp_a); end
    end
    @(negedge clock);
    checks++;
    if ({a_hex[1], a_hex[0]} !== {7'h40, 7'h12})
      begin fails++; $display("FAIL reset_edge9: got %h expected %h", {a_hex[1], a_hex[0]}, {7'h40, 7'h12}); end
  endtask

  task automatic test_in_range();
    p_in[0] = 32'd42; p_in[1] = 32'd99; p_in[2] = 32'd7;
    for (int i = 0; i < 54; i++) begin
      @(negedge clock);
      checks++;
      if (obs_a !== exp_a) begin fails++; $display("FAIL in_range_a: got %h expected %h", obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin fails++; $display("FAIL in_range_b: got %h expected %h", obs_b, exp_b); end
    end
    checks++;
    if ({a_hex[5], a_hex[4], a_hex[3], a_hex[2], a_hex[1], a_hex[0], a_ovf} !==
        {7'h40, 7'h78, 7'h10, 7'h10, 7'h19, 7'h24, 3'b000})
      begin fails++; $display("FAIL in_range_const: got %h", {a_hex[5], a_hex[4], a_hex[3], a_hex[2], a_hex[1], a_hex[0], a_ovf}); end
  endtask

  task automatic test_overflow();
    logic [31:0] vals [3];
    vals[0] = 32'd100; vals[1] = 32'h0000_0080; vals[2] = 32'h8000_0005;
    for (int v = 0; v < 3; v++) begin
      p_in[1] = vals[v];
      for (int i = 0; i < 36; i++) begin
        @(negedge clock);
        checks++;
        if (obs_a !== exp_a) begin fails++; $display("FAIL ovf_model %h: got %h expected %h", vals[v], obs_a, exp_a); end
      end
      checks++;
      if ({a_hex[3], a_hex[2], a_ovf[1]} !== {7'h3F, 7'h3F, 1'b1})
        begin fails++; $display("FAIL ovf_dash %h: got %h", vals[v], {a_hex[3], a_hex[2], a_ovf[1]}); end
      checks++;
      if ({b_hex[3], b_hex[2], b_ovf[1]} !== {7'h3F, 7'h3F, 1'b1})
        begin fails++; $display("FAIL ovf_dash_lb %h: got %h", vals[v], {b_hex[3], b_hex[2], b_ovf[1]}); end
    end
    p_in[1] = 32'd5;
    repeat (35) @(negedge clock);
    checks++;
    if ({a_hex[3], a_hex[2], a_ovf[1]} !== {7'h40, 7'h12, 1'b0})
      begin fails++; $display("FAIL ovf_restore: got %h", {a_hex[3], a_hex[2], a_ovf[1]}); end
    checks++;
    if ({b_hex[3], b_hex[2], b_ovf[1]} !== {7'h7F, 7'h12, 1'b0})
      begin fails++; $display("FAIL ovf_restore_lb: got %h", {b_hex[3], b_hex[2], b_ovf[1]}); end
  endtask

  task automatic test_lead_blank();
    p_in[2] = 32'd0;
    repeat (36) @(negedge clock);
    checks++;
    if ({b_hex[5], b_hex[4]} !== {7'h7F, 7'h40})
      begin fails++; $display("FAIL lead_blank_zero: got %h", {b_hex[5], b_hex[4]}); end
    checks++;
    if ({a_hex[5], a_hex[4]} !== {7'h40, 7'h40})
      begin fails++; $display("FAIL no_lead_blank_zero: got %h", {a_hex[5], a_hex[4]}); end
    p_in[2] = 32'd30;
    repeat (36) @(negedge clock);
    checks++;
    if ({b_hex[5], b_hex[4]} !== {7'h30, 7'h40})
      begin fails++; $display("FAIL lead_blank_30: got %h", {b_hex[5], b_hex[4]}); end
  endtask

  task automatic test_mid_change();
    int k;
    bit seen;
    p_in[0] = 32'd12;
    repeat (36) @(negedge clock);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clock);
      if (m_pos == 0) seen = 1;
    end
    checks++;
    if (!seen) begin fails++; $display("FAIL mid_align: got timeout expected ch0 LOAD"); end
    p_in[0] = 32'd34;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if (obs_a !== exp_a) begin fails++; $display("FAIL mid_model: got %h expected %h", obs_a, exp_a); end
    end
    checks++;
    if ({a_hex[1], a_hex[0]} !== {7'h79, 7'h24})
      begin fails++; $display("FAIL mid_old: got %h expected %h", {a_hex[1], a_hex[0]}, {7'h79, 7'h24}); end
    repeat (27) @(negedge clock);
    checks++;
    if ({a_hex[1], a_hex[0]} !== {7'h30, 7'h19})
      begin fails++; $display("FAIL mid_new: got %h expected %h", {a_hex[1], a_hex[0]}, {7'h30, 7'h19}); end
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clock);
      if (a_fd) seen = 1;
    end
    checks++;
    if (!seen) begin fails++; $display("FAIL fd_first: got timeout expected pulse"); end
    for (int p = 0; p < 2; p++) begin
      k = 0;
      seen = 0;
      while (!seen && k < 40) begin
        @(negedge clock);
        k++;
        if (a_fd) seen = 1;
      end
      checks++;
      if (k != 27) begin fails++; $display("FAIL fd_period: got %0d expected 27", k); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clock);
      if (m_pos == 11) seen = 1;
    end
    checks++;
    if (!seen) begin fails++; $display("FAIL rmid_align: got timeout expected ch1 SHIFT"); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (obs_a !== ALL_BLANK) begin fails++; $display("FAIL rmid_blank: got %h expected %h", obs_a, ALL_BLANK); end
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if (obs_a !== exp_a) begin fails++; $display("FAIL rmid_model: got %h expected %h", obs_a, exp_a); end
    end
    @(negedge clock);
    checks++;
    if ({a_hex[3], a_hex[2], a_hex[1], a_hex[0]} !== {7'h7F, 7'h7F, 7'h30, 7'h19})
      begin fails++; $display("FAIL rmid_edge9: got %h", {a_hex[3], a_hex[2], a_hex[1], a_hex[0]}); end
    repeat (8) @(negedge clock);
    checks++;
    if ({a_hex[3], a_hex[2]} !== {7'h7F, 7'h7F})
      begin fails++; $display("FAIL rmid_stale: got %h expected 3fff", {a_hex[3], a_hex[2]}); end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 25; it++) begin
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 3) == 0) p_in[c] = $urandom;
          else                           p_in[c] = $urandom_range(0, 127);
        end
      end
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        @(negedge clock);
        checks++;
        if (obs_a !== exp_a) begin fails++; $display("FAIL random_a: got %h expected %h", obs_a, exp_a); end
        checks++;
        if (obs_b !== exp_b) begin fails++; $display("FAIL random_b: got %h expected %h", obs_b, exp_b); end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    test_reset();
    test_in_range();
    test_overflow();
    test_lead_blank();
    test_mid_change();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/out_port_hex_display.md
# out_port_hex_display

Sequential output stage that sits directly downstream of `pipelined_computer`. It takes the three 32-bit output ports (`out_port0`, `out_port1`, `out_port2`) and drives the six active-low seven-segment displays `HEX0`–`HEX5` on the DE1-SoC board, two decimal digits per port. One shared double-dabble engine converts the ports round-robin. Each port is shown as decimal 00–99; larger values are flagged as overflow.

## Interface
- `LEAD_BLANK`, default 0: when 1, a tens digit of zero is blanked instead of showing "0".
- `clock`  in  1  system clock; the CPU clock domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `out_port0`  in  32  value shown on HEX1 (tens) and HEX0 (ones).
- `out_port1`  in  32  value shown on HEX3 (tens) and HEX2 (ones).
- `out_port2`  in  32  value shown on HEX5 (tens) and HEX4 (ones).
- `HEX0`…`HEX5`  out  7 each  active-low segment vectors, bit order gfedcba, registered.
- `ovf`  out  3  bit c set while channel c last converted a value > 99, registered.
- `frame_done`  out  1  one-cycle pulse when channel 2's result is stored.

## Operation
- **Clock and reset:** one clock, `clock`. Reset is asynchronous and active-low on `resetn`.
- **State machine:** states LOAD, SHIFT, STORE. A channel counter `ch` counts 0→1→2→0.
- **LOAD (1 cycle):**
  - Snapshot `out_port[ch]` in full.
  - Compute `over = (value > 99)` against all 32 bits.
  - Load the low 7 bits into the binary shift register.
  - Clear the 8-bit BCD register (tens:ones).
  - Clear the shift counter. Go to SHIFT.
- **SHIFT (7 cycles):**
  - Each cycle, add 3 to any BCD nibble ≥ 5.
  - Then shift {BCD, binary} left by one, moving the binary MSB into the BCD LSB.
  - After the 7th shift, go to STORE.
- **STORE (1 cycle):**
  - Write the segment patterns for channel `ch` and set `ovf[ch] = over`.
  - If `ch` = 2, pulse `frame_done`.
  - Advance `ch` with wrap-around 2→0, then go to LOAD.
- **Segment codes (active-low, gfedcba):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111, blank=1111111.
- **Overflow:** if `over` is set, both digits of the channel show dash. Conversion timing is unchanged; the low-7-bit result is discarded.
- **LEAD_BLANK = 1:** the tens digit shows blank when the BCD tens nibble is 0 and `over` = 0. The ones digit is never blanked.
- **Input changes:** a port change during its own conversion or another channel's conversion is ignored until that channel's next LOAD.
- **Outputs between writes:** each HEX pair holds its value until its channel's next STORE.
- **BCD range:** the BCD result never exceeds 99 for 7-bit input ≤ 99. Inputs 100–127 are handled by `over`, so no hundreds digit exists.

## Timing
- **Reset values:**
  - All `HEX` = 1111111 (blank).
  - `ovf` = 000, `frame_done` = 0.
  - FSM in LOAD with `ch` = 0; shift and BCD registers cleared.
- **Reset is asynchronous and may assert mid-conversion:** all outputs and state return to reset values immediately. After release, the first active edge performs LOAD of channel 0.
- **Per-channel period:** 9 cycles (1 LOAD + 7 SHIFT + 1 STORE). Full frame period is 27 cycles.
- **Latency:** a channel's HEX/`ovf` update at the STORE edge, 8 cycles after its LOAD edge.
- **Worst-case latency** from a port change to display: 27 + 8 = 35 cycles.
- **First frame after reset release:**
  - HEX1/HEX0 update on edge 9, HEX3/HEX2 on edge 18, HEX5/HEX4 on edge 27.
  - `frame_done` is high during the cycle after edge 27, then every 27 cycles.
- There is no handshake; the block is free-running.

## Test plan
- **Reset:** hold `resetn`=0 with ports = 5 → all HEX = 1111111, `ovf` = 000, `frame_done` = 0. Release → HEX0 = 0010010 and HEX1 = 1000000 after edge 9.
- **In-range values:** `out_port0`=42, `out_port1`=99, `out_port2`=7 → after one frame:
  - HEX1 = 0011001, HEX0 = 0100100
  - HEX3 = HEX2 = 0010000
  - HEX5 = 1000000, HEX4 = 1111000
  - `ovf` = 000.
- **Overflow:** `out_port1`=100, then 0x0000_0080, then 0x8000_0005 → HEX3 = HEX2 = 0111111 and `ovf[1]` = 1 each time. Then `out_port1`=5 → restored to "05" and `ovf[1]` = 0 within 35 cycles.
- **LEAD_BLANK=1:** `out_port2`=0 → HEX5 = 1111111, HEX4 = 1000000. With `out_port2`=30 → HEX5 = 0110000, HEX4 = 1000000.
- **Input change mid-conversion:**
  - Change `out_port0` 12→34 during channel 0 SHIFT → that STORE shows "12"; the next frame shows "34".
  - Check `frame_done` pulses exactly every 27 cycles.
- **Reset mid-operation:** assert `resetn` during channel 1 SHIFT → outputs blank immediately. Release → channel 0 updates on edge 9, with no stale channel-1 write.
